// File: rtl/croc_pkg.sv
// Croc shared types: OBI/regbus bundles, address rules
// and programmable demux constants.
package croc_pkg;

  localparam int unsigned AidWidth = 4;

  localparam logic [31:0] ProgDemuxRuleStride = 32'h10;
  localparam int unsigned ProgDemuxCtrlEnBit = 0;
  localparam int unsigned ProgDemuxCtrlLockBit = 1;
  localparam logic [31:0] ObiErrRdata = 32'hBADCAB1E;

  typedef enum logic [1:0] {
    RegStart = 2'd0,
    RegEnd   = 2'd1,
    RegIdx   = 2'd2,
    RegCtrl  = 2'd3
  } prog_reg_e;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  typedef struct packed {
    addr_map_rule_t rule;
    logic           en;
    logic           lock;
  } prog_rule_t;

  typedef struct packed {
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [AidWidth-1:0] aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]         rdata;
    logic [AidWidth-1:0] rid;
    logic                err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  // Unsigned, END-exclusive; START >= END can never hit.
  function automatic logic rule_hit(prog_rule_t r,
                                    logic [31:0] addr);
    return r.en &&
           (addr >= r.rule.start_addr) &&
           (addr < r.rule.end_addr);
  endfunction

endpackage

// File: rtl/croc_obi_err_sbr.sv
// OBI error subordinate: grants every request and answers
// one cycle later with err=1, a fixed rdata and the echoed aid.
module croc_obi_err_sbr
  import croc_pkg::*;
#(
  parameter type obi_req_t = sbr_obi_req_t,
  parameter type obi_rsp_t = sbr_obi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o
);

  obi_rsp_t rsp_q;

  // Capture aid on each accepted request; respond next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= '0;
      if (obi_req_i.req) begin
        rsp_q.rvalid  <= 1'b1;
        rsp_q.r.rid   <= obi_req_i.a.aid;
        rsp_q.r.rdata <= ObiErrRdata;
        rsp_q.r.err   <= 1'b1;
      end
    end
  end

  // Always ready, so back-to-back requests are accepted.
  always_comb begin
    obi_rsp_o     = rsp_q;
    obi_rsp_o.gnt = 1'b1;
  end

  logic unused_req;
  assign unused_req = ^{obi_req_i.a.addr, obi_req_i.a.we,
                        obi_req_i.a.be, obi_req_i.a.wdata};

endmodule

// File: rtl/croc_obi_prog_demux.sv
// OBI demux with a regbus-programmable, lockable rule table
// and in-order response tracking.
module croc_obi_prog_demux
  import croc_pkg::*;
#(
  parameter int unsigned NumRules = 4,
  parameter int unsigned NumSbr = 4,
  parameter int unsigned MaxTrans = 4,
  parameter addr_map_rule_t [NumRules-1:0] DefaultRules = '0,
  parameter type obi_req_t = sbr_obi_req_t,
  parameter type obi_rsp_t = sbr_obi_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  obi_req_t              mgr_req_i,
  output obi_rsp_t              mgr_rsp_o,
  output obi_req_t [NumSbr-1:0] sbr_req_o,
  input  obi_rsp_t [NumSbr-1:0] sbr_rsp_i,
  input  reg_req_t              reg_req_i,
  output reg_rsp_t              reg_rsp_o
);

  localparam int unsigned SelW = $clog2(NumSbr + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [SelW-1:0] ErrSel = SelW'(NumSbr);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

  prog_rule_t [NumRules-1:0] rules_q;
  logic [NumRules-1:0]       wr_en;
  logic                      reg_hit;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] last_sel_q, last_sel_d;
  logic [SelW-1:0] sel;
  logic            found;
  logic            allow;
  logic            sel_gnt;
  logic            hs;
  logic            rsp_rvalid;
  logic            live;

  obi_req_t err_req;
  obi_rsp_t err_rsp;
  obi_rsp_t rsp_mux;

  // Regbus decode: combinational read data, lock-aware write enables.
  always_comb begin
    reg_rsp_o = '0;
    wr_en     = '0;
    reg_hit   = 1'b0;
    if (reg_req_i.valid) begin
      reg_rsp_o.ready = 1'b1;
      for (int i = 0; i < NumRules; i++) begin
        if (reg_req_i.addr[1:0] == 2'b00 &&
            (reg_req_i.addr & ~(ProgDemuxRuleStride - 32'd1)) ==
            ProgDemuxRuleStride * 32'(i)) begin
          reg_hit = 1'b1;
          unique case (prog_reg_e'(reg_req_i.addr[3:2]))
            RegStart: reg_rsp_o.rdata = rules_q[i].rule.start_addr;
            RegEnd:   reg_rsp_o.rdata = rules_q[i].rule.end_addr;
            RegIdx:   reg_rsp_o.rdata = rules_q[i].rule.idx;
            RegCtrl: begin
              reg_rsp_o.rdata[ProgDemuxCtrlEnBit] = rules_q[i].en;
              reg_rsp_o.rdata[ProgDemuxCtrlLockBit] = rules_q[i].lock;
            end
            default: ;
          endcase
          if (reg_req_i.write) begin
            if (rules_q[i].lock) reg_rsp_o.error = 1'b1;
            else wr_en[i] = 1'b1;
          end
        end
      end
      if (!reg_hit) reg_rsp_o.error = 1'b1;
    end
  end

  // Rule table: reset to defaults (enabled, unlocked); LOCK is sticky.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRules; i++) begin
        rules_q[i] <= '{rule: DefaultRules[i], en: 1'b1, lock: 1'b0};
      end
    end else begin
      for (int i = 0; i < NumRules; i++) begin
        if (wr_en[i]) begin
          unique case (prog_reg_e'(reg_req_i.addr[3:2]))
            RegStart: rules_q[i].rule.start_addr <= reg_req_i.wdata;
            RegEnd:   rules_q[i].rule.end_addr <= reg_req_i.wdata;
            RegIdx:   rules_q[i].rule.idx <= reg_req_i.wdata;
            RegCtrl: begin
              rules_q[i].en <= reg_req_i.wdata[ProgDemuxCtrlEnBit];
              rules_q[i].lock <= rules_q[i].lock |
                                 reg_req_i.wdata[ProgDemuxCtrlLockBit];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Priority decode: lowest matching rule wins; bad IDX -> error port.
  always_comb begin
    sel   = ErrSel;
    found = 1'b0;
    for (int i = 0; i < NumRules; i++) begin
      if (!found && rule_hit(rules_q[i], mgr_req_i.a.addr)) begin
        found = 1'b1;
        if (rules_q[i].rule.idx < 32'(NumSbr)) begin
          sel = rules_q[i].rule.idx[SelW-1:0];
        end
      end
    end
  end

  assign allow = mgr_req_i.req && (cnt_q < CntMax) &&
                 (cnt_q == '0 || sel == last_sel_q);

  // Request fan-out to the selected port only; grant fan-in.
  always_comb begin
    sbr_req_o = '0;
    err_req   = '0;
    sel_gnt   = 1'b0;
    for (int j = 0; j < NumSbr; j++) begin
      if (allow && sel == SelW'(j)) begin
        sbr_req_o[j] = mgr_req_i;
        sel_gnt      = sbr_rsp_i[j].gnt;
      end
    end
    if (allow && sel == ErrSel) begin
      err_req = mgr_req_i;
      sel_gnt = err_rsp.gnt;
    end
  end

  assign hs = allow && sel_gnt;

  croc_obi_err_sbr #(
    .obi_req_t(obi_req_t),
    .obi_rsp_t(obi_rsp_t)
  ) i_err_sbr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .obi_req_i(err_req),
    .obi_rsp_o(err_rsp)
  );

  // Response path follows the port of the last accepted request.
  always_comb begin
    rsp_mux = err_rsp;
    for (int j = 0; j < NumSbr; j++) begin
      if (last_sel_q == SelW'(j)) rsp_mux = sbr_rsp_i[j];
    end
  end

  assign rsp_rvalid = rsp_mux.rvalid;
  assign live       = rsp_rvalid && (cnt_q != '0);

  // Manager response; stale rvalid with nothing outstanding is dropped.
  always_comb begin
    mgr_rsp_o     = '0;
    mgr_rsp_o.gnt = hs;
    if (live) begin
      mgr_rsp_o.rvalid = 1'b1;
      mgr_rsp_o.r      = rsp_mux.r;
    end
  end

  // Outstanding counter and target tracking.
  always_comb begin
    cnt_d      = cnt_q;
    last_sel_d = last_sel_q;
    if (hs) last_sel_d = sel;
    unique case ({hs, live})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: ;
    endcase
  end

  // Counter and last-target registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      last_sel_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      last_sel_q <= last_sel_d;
    end
  end

  a_no_underflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(rsp_rvalid && cnt_q == '0)
  );

  logic unused_sig;
  assign unused_sig = ^{reg_req_i.wstrb, rsp_mux.gnt};

endmodule

// File: tb/tb_croc_obi_prog_demux.sv
// Directed bench for croc_obi_prog_demux: decode table plus
// handshake, stall, regbus-lock and reset sequences.
module tb_croc_obi_prog_demux;
  import croc_pkg::*;

  localparam addr_map_rule_t [3:0] TbRules = '{
    '0,
    '0,
    '{idx: 32'd2, start_addr: 32'h1000, end_addr: 32'h2000},
    '{idx: 32'd1, start_addr: 32'h0000, end_addr: 32'h1000}
  };

  logic clk;
  logic rst_n;
  sbr_obi_req_t       mgr_req;
  sbr_obi_rsp_t       mgr_rsp;
  sbr_obi_req_t [3:0] sbr_req;
  sbr_obi_rsp_t [3:0] sbr_rsp;
  reg_req_t           reg_req;
  reg_rsp_t           reg_rsp;

  int n_chk;
  int n_fail;

  croc_obi_prog_demux #(
    .NumRules    (4),
    .NumSbr      (4),
    .MaxTrans    (4),
    .DefaultRules(TbRules)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .mgr_req_i(mgr_req),
    .mgr_rsp_o(mgr_rsp),
    .sbr_req_o(sbr_req),
    .sbr_rsp_i(sbr_rsp),
    .reg_req_i(reg_req),
    .reg_rsp_o(reg_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  aid;
    logic [3:0]  exp_mask;
    logic        exp_gnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] req_mask();
    logic [3:0] m;
    for (int j = 0; j < 4; j++) m[j] = sbr_req[j].req;
    return m;
  endfunction

  task automatic mgr_set(input logic rq, input logic [31:0] ad,
                         input logic [3:0] id);
    mgr_req.req    = rq;
    mgr_req.a.addr = ad;
    mgr_req.a.aid  = id;
  endtask

  task automatic reg_wr(input logic [31:0] ad, input logic [31:0] d,
                        input logic exp_err, input string name);
    @(negedge clk);
    reg_req.valid = 1'b1;
    reg_req.write = 1'b1;
    reg_req.addr  = ad;
    reg_req.wdata = d;
    #1;
    chk({name, "_err"}, 32'(reg_rsp.error), 32'(exp_err));
    chk({name, "_rdy"}, 32'(reg_rsp.ready), 32'd1);
    @(posedge clk);
    #1;
    reg_req.valid = 1'b0;
    reg_req.write = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] ad, input logic [31:0] exp_d,
                        input logic exp_err, input string name);
    @(negedge clk);
    reg_req.valid = 1'b1;
    reg_req.write = 1'b0;
    reg_req.addr  = ad;
    #1;
    chk({name, "_rdata"}, reg_rsp.rdata, exp_d);
    chk({name, "_err"}, 32'(reg_rsp.error), 32'(exp_err));
    reg_req.valid = 1'b0;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    mgr_req = '0;
    sbr_rsp = '0;
    reg_req = '0;

    vecs[0] = '{32'h0000_0000, 4'd1, 4'b0010, 1'b1};
    vecs[1] = '{32'h0000_0FFC, 4'd2, 4'b0010, 1'b1};
    vecs[2] = '{32'h0000_1000, 4'd3, 4'b0100, 1'b0};
    vecs[3] = '{32'h0000_1004, 4'd4, 4'b0100, 1'b0};
    vecs[4] = '{32'h0000_1FFC, 4'd5, 4'b0100, 1'b0};
    vecs[5] = '{32'h0000_2000, 4'd6, 4'b0000, 1'b1};
    vecs[6] = '{32'h0000_9000, 4'd7, 4'b0000, 1'b1};
    vecs[7] = '{32'hFFFF_FFFC, 4'd8, 4'b0000, 1'b1};

    #12;
    chk("rst_mgr_rsp", 32'(|mgr_rsp), 32'd0);
    chk("rst_sbr_req", 32'(|sbr_req), 32'd0);
    chk("rst_reg_rsp", 32'(|reg_rsp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational decode; req dropped before the edge.
    sbr_rsp[1].gnt = 1'b1;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      mgr_set(1'b1, vecs[v].addr, vecs[v].aid);
      #1;
      chk($sformatf("vec%0d_mask", v), 32'(req_mask()),
          32'(vecs[v].exp_mask));
      chk($sformatf("vec%0d_gnt", v), 32'(mgr_rsp.gnt),
          32'(vecs[v].exp_gnt));
      for (int j = 0; j < 4; j++) begin
        if (vecs[v].exp_mask[j]) begin
          chk($sformatf("vec%0d_addr", v), sbr_req[j].a.addr,
              vecs[v].addr);
          chk($sformatf("vec%0d_aid", v), 32'(sbr_req[j].a.aid),
              32'(vecs[v].aid));
        end
      end
      mgr_set(1'b0, 32'h0, 4'd0);
    end

    // Port 2 read round trip.
    sbr_rsp[2].gnt = 1'b1;
    @(negedge clk);
    mgr_set(1'b1, 32'h1004, 4'd5);
    #1;
    chk("a_mask", 32'(req_mask()), 32'b0100);
    chk("a_gnt", 32'(mgr_rsp.gnt), 32'd1);
    @(negedge clk);
    mgr_set(1'b0, 32'h0, 4'd0);
    sbr_rsp[2].rvalid  = 1'b1;
    sbr_rsp[2].r.rdata = 32'h1234_5678;
    sbr_rsp[2].r.rid   = 4'd5;
    sbr_rsp[2].r.err   = 1'b0;
    #1;
    chk("a_rvalid", 32'(mgr_rsp.rvalid), 32'd1);
    chk("a_rdata", mgr_rsp.r.rdata, 32'h1234_5678);
    chk("a_err", 32'(mgr_rsp.r.err), 32'd0);
    chk("a_rid", 32'(mgr_rsp.r.rid), 32'd5);
    @(negedge clk);
    sbr_rsp[2].rvalid = 1'b0;
    #1;
    chk("a_rvalid_off", 32'(mgr_rsp.rvalid), 32'd0);

    // Error subordinate.
    @(negedge clk);
    mgr_set(1'b1, 32'h9000, 4'd3);
    #1;
    chk("b_gnt", 32'(mgr_rsp.gnt), 32'd1);
    chk("b_mask", 32'(req_mask()), 32'd0);
    @(negedge clk);
    mgr_set(1'b0, 32'h0, 4'd0);
    #1;
    chk("b_rvalid", 32'(mgr_rsp.rvalid), 32'd1);
    chk("b_err", 32'(mgr_rsp.r.err), 32'd1);
    chk("b_rdata", mgr_rsp.r.rdata, 32'hBADC_AB1E);
    chk("b_rid", 32'(mgr_rsp.r.rid), 32'd3);
    @(negedge clk);
    #1;
    chk("b_rvalid_off", 32'(mgr_rsp.rvalid), 32'd0);

    // MaxTrans stall and release.
    @(negedge clk);
    mgr_set(1'b1, 32'h0, 4'd1);
    #1;
    chk("c_issue0", 32'(mgr_rsp.gnt), 32'd1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("c_issue%0d", k), 32'(mgr_rsp.gnt), 32'd1);
    end
    @(negedge clk);
    #1;
    chk("c_full_gnt", 32'(mgr_rsp.gnt), 32'd0);
    chk("c_full_req", 32'(sbr_req[1].req), 32'd0);
    sbr_rsp[1].rvalid = 1'b1;
    #1;
    chk("c_rsp_gnt", 32'(mgr_rsp.gnt), 32'd0);
    chk("c_rsp_rvalid", 32'(mgr_rsp.rvalid), 32'd1);
    @(negedge clk);
    sbr_rsp[1].rvalid = 1'b0;
    #1;
    chk("c_fifth_gnt", 32'(mgr_rsp.gnt), 32'd1);
    @(negedge clk);
    mgr_set(1'b0, 32'h0, 4'd0);
    sbr_rsp[1].rvalid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sbr_rsp[1].rvalid = 1'b0;

    // Target switch waits for the outstanding response.
    @(negedge clk);
    mgr_set(1'b1, 32'h0, 4'd2);
    @(negedge clk);
    mgr_set(1'b1, 32'h1000, 4'd2);
    #1;
    chk("d_wait_req", 32'(sbr_req[2].req), 32'd0);
    chk("d_wait_gnt", 32'(mgr_rsp.gnt), 32'd0);
    @(negedge clk);
    sbr_rsp[1].rvalid = 1'b1;
    #1;
    chk("d_rsp_req", 32'(sbr_req[2].req), 32'd0);
    @(negedge clk);
    sbr_rsp[1].rvalid = 1'b0;
    #1;
    chk("d_go_req", 32'(sbr_req[2].req), 32'd1);
    chk("d_go_gnt", 32'(mgr_rsp.gnt), 32'd1);
    @(negedge clk);
    mgr_set(1'b0, 32'h0, 4'd0);
    sbr_rsp[2].rvalid = 1'b1;
    @(negedge clk);
    sbr_rsp[2].rvalid = 1'b0;

    // Regbus programming and lock.
    reg_wr(32'h04, 32'h800, 1'b0, "e_wr_end");
    reg_wr(32'h0C, 32'h3, 1'b0, "e_wr_lock");
    reg_rd(32'h0C, 32'h3, 1'b0, "e_rd_ctrl");
    @(negedge clk);
    mgr_set(1'b1, 32'h900, 4'd1);
    #1;
    chk("e_900_mask", 32'(req_mask()), 32'd0);
    chk("e_900_gnt", 32'(mgr_rsp.gnt), 32'd1);
    mgr_set(1'b0, 32'h0, 4'd0);
    reg_wr(32'h00, 32'h100, 1'b1, "e_wr_locked");
    reg_rd(32'h00, 32'h0, 1'b0, "e_rd_start");
    reg_wr(32'h0C, 32'h0, 1'b1, "e_wr_ctrl_locked");
    reg_rd(32'h0C, 32'h3, 1'b0, "e_rd_ctrl2");
    reg_rd(32'h18, 32'h2, 1'b0, "e_rd_idx1");
    reg_rd(32'h40, 32'h0, 1'b1, "e_rd_unmapped");
    reg_rd(32'h02, 32'h0, 1'b1, "e_rd_misaligned");

    // Reset with two transactions outstanding.
    @(negedge clk);
    mgr_set(1'b1, 32'h0, 4'd1);
    @(negedge clk);
    @(negedge clk);
    mgr_set(1'b0, 32'h0, 4'd0);
    rst_n = 1'b0;
    #1;
    chk("f_mgr_rsp", 32'(|mgr_rsp), 32'd0);
    chk("f_sbr_req", 32'(|sbr_req), 32'd0);
    chk("f_reg_rsp", 32'(|reg_rsp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reg_rd(32'h04, 32'h1000, 1'b0, "f_rd_end");
    reg_rd(32'h0C, 32'h1, 1'b0, "f_rd_ctrl");
    reg_wr(32'h00, 32'h0, 1'b0, "f_wr_unlocked");
    @(negedge clk);
    mgr_set(1'b1, 32'h1000, 4'd1);
    #1;
    chk("f_issue_req", 32'(sbr_req[2].req), 32'd1);
    chk("f_issue_gnt", 32'(mgr_rsp.gnt), 32'd1);
    mgr_set(1'b0, 32'h0, 4'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
